// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM addressing, IR capture, valid/ready handoff.
// Define FETCH_END_DETECT_EN to enable END-opcode detection and the halt state.
module fetch_unit #(
    parameter logic [7:0] PC_RESET   = 8'd0,
    parameter logic [3:0] END_OPCODE = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    output logic [7:0]  iram_addr,
    input  logic [15:0] iram_q,
    output logic [15:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        branch_en,
    input  logic [7:0]  branch_target,
    output logic [7:0]  pc,
    output logic        halted
);

`ifdef FETCH_END_DETECT_EN
    localparam logic END_EN = 1'b1;
`else
    localparam logic END_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_ISSUE,
        S_CAPTURE,
        S_HOLD,
        S_HALT
    } state_t;

    state_t state;
    logic   is_end;

    assign iram_addr = pc;
    assign is_end    = END_EN && (ir[15:12] == END_OPCODE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_ISSUE;
            pc       <= PC_RESET;
            ir       <= 16'h0000;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else if (branch_en && state != S_HALT) begin
            // Redirect wins over capture and accept; any in-flight word is lost.
            pc       <= branch_target;
            ir_valid <= 1'b0;
            state    <= S_ISSUE;
        end else begin
            unique case (state)
                S_ISSUE: begin
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    ir       <= iram_q;
                    ir_valid <= 1'b1;
                    pc       <= pc + 8'd1;
                    state    <= S_HOLD;
                end
                S_HOLD: begin
                    if (ir_ready) begin
                        ir_valid <= 1'b0;
                        if (is_end) begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rst_w = 1'b0;
    logic [7:0]  iram_addr, iram_addr_w;
    logic [15:0] iram_q, iram_q_w;
    logic [15:0] ir, ir_w;
    logic        ir_valid, ir_valid_w;
    logic        ir_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic [7:0]  pc, pc_w;
    logic        halted, halted_w;

    logic [15:0] rom [256];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        iram_q   <= rom[iram_addr];
        iram_q_w <= rom[iram_addr_w];
    end

    fetch_unit dut (
        .clock(clock), .reset(reset), .iram_addr(iram_addr), .iram_q(iram_q),
        .ir(ir), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .branch_en(branch_en), .branch_target(branch_target),
        .pc(pc), .halted(halted)
    );

    fetch_unit #(.PC_RESET(8'hFF)) dut_w (
        .clock(clock), .reset(rst_w), .iram_addr(iram_addr_w), .iram_q(iram_q_w),
        .ir(ir_w), .ir_valid(ir_valid_w), .ir_ready(ir_ready),
        .branch_en(branch_en), .branch_target(branch_target),
        .pc(pc_w), .halted(halted_w)
    );

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        ir_ready = 1'b0;
        branch_en = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!ir_valid && n < max);
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        n_chk++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want 00", pc); end
        n_chk++; if (iram_addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", iram_addr); end
        n_chk++; if (ir !== 16'h0000) begin n_fail++; $display("FAIL reset_ir: got %h want 0000", ir); end
        n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ir_valid); end
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", halted); end
    endtask

    task automatic test_basic;
        int n;
        rom[0] = 16'hC07F;
        rom[1] = 16'h3102;
        do_reset();
        ir_ready = 1'b1;
        wait_valid(20, n);
        n_chk++; if (n != 2) begin n_fail++; $display("FAIL basic_lat0: got %0d edges want 2", n); end
        n_chk++; if (ir !== 16'hC07F) begin n_fail++; $display("FAIL basic_ir0: got %h want C07F", ir); end
        n_chk++; if (pc !== 8'h01) begin n_fail++; $display("FAIL basic_pc0: got %h want 01", pc); end
        wait_valid(20, n);
        n_chk++; if (n != 3) begin n_fail++; $display("FAIL basic_lat1: got %0d edges want 3", n); end
        n_chk++; if (ir !== 16'h3102) begin n_fail++; $display("FAIL basic_ir1: got %h want 3102", ir); end
        n_chk++; if (pc !== 8'h02) begin n_fail++; $display("FAIL basic_pc1: got %h want 02", pc); end
    endtask

    task automatic test_stall;
        int n;
        do_reset();
        wait_valid(20, n);
        n_chk++; if (n != 2 || ir !== rom[0]) begin n_fail++; $display("FAIL stall_first: got %h after %0d want %h after 2", ir, n, rom[0]); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_chk++; if (ir !== rom[0]) begin n_fail++; $display("FAIL stall_ir: got %h want %h", ir, rom[0]); end
            n_chk++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %b want 1", ir_valid); end
            n_chk++; if (pc !== 8'h01) begin n_fail++; $display("FAIL stall_pc: got %h want 01", pc); end
        end
        ir_ready = 1'b1;
        step();
        ir_ready = 1'b0;
        n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL stall_accept: got %b want 0", ir_valid); end
        wait_valid(20, n);
        n_chk++; if (n != 2) begin n_fail++; $display("FAIL stall_lat: got %0d edges want 2", n); end
        n_chk++; if (ir !== rom[1]) begin n_fail++; $display("FAIL stall_next: got %h want %h", ir, rom[1]); end
        n_chk++; if (pc !== 8'h02) begin n_fail++; $display("FAIL stall_pc2: got %h want 02", pc); end
    endtask

    task automatic test_branch;
        int n;
        do_reset();
        wait_valid(20, n);
        ir_ready = 1'b1;
        branch_en = 1'b1;
        branch_target = 8'h0A;
        step();
        branch_en = 1'b0;
        n_chk++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL br_drop: got %b want 0", ir_valid); end
        n_chk++; if (iram_addr !== 8'h0A) begin n_fail++; $display("FAIL br_addr: got %h want 0A", iram_addr); end
        wait_valid(20, n);
        n_chk++; if (n != 2) begin n_fail++; $display("FAIL br_lat: got %0d edges want 2", n); end
        n_chk++; if (ir !== rom[10]) begin n_fail++; $display("FAIL br_ir: got %h want %h", ir, rom[10]); end
        n_chk++; if (pc !== 8'h0B) begin n_fail++; $display("FAIL br_pc: got %h want 0B", pc); end
    endtask

    task automatic test_wrap;
        int n;
        ir_ready = 1'b1;
        branch_en = 1'b0;
        rst_w = 1'b0;
        step();
        n_chk++; if (pc_w !== 8'hFF) begin n_fail++; $display("FAIL wrap_reset_pc: got %h want FF", pc_w); end
        rst_w = 1'b1;
        n = 0;
        do begin step(); n++; end while (!ir_valid_w && n < 20);
        n_chk++; if (n != 2 || ir_w !== rom[255]) begin n_fail++; $display("FAIL wrap_ir255: got %h after %0d want %h after 2", ir_w, n, rom[255]); end
        n_chk++; if (pc_w !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h want 00", pc_w); end
        n = 0;
        do begin step(); n++; end while (!ir_valid_w && n < 20);
        n_chk++; if (n != 3 || ir_w !== rom[0]) begin n_fail++; $display("FAIL wrap_ir0: got %h after %0d want %h after 3", ir_w, n, rom[0]); end
        n_chk++; if (pc_w !== 8'h01) begin n_fail++; $display("FAIL wrap_pc1: got %h want 01", pc_w); end
        rst_w = 1'b0;
    endtask

    task automatic test_end;
        int n;
        rom[100] = 16'hF000;
        rom[101] = 16'h1234;
        do_reset();
        branch_en = 1'b1;
        branch_target = 8'd100;
        step();
        branch_en = 1'b0;
        wait_valid(20, n);
        n_chk++; if (n != 2 || ir !== 16'hF000) begin n_fail++; $display("FAIL end_word: got %h after %0d want F000 after 2", ir, n); end
        ir_ready = 1'b1;
        step();
`ifdef FETCH_END_DETECT_EN
        n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL end_halted: got %b want 1", halted); end
        branch_en = 1'b1;
        branch_target = 8'h05;
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++; if (pc !== 8'd101) begin n_fail++; $display("FAIL end_pc_frozen: got %h want 65", pc); end
            n_chk++; if (ir_valid !== 1'b0 || halted !== 1'b1) begin n_fail++; $display("FAIL end_frozen: got valid %b halted %b want 0 1", ir_valid, halted); end
        end
        branch_en = 1'b0;
        reset = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0 || pc !== 8'h00) begin n_fail++; $display("FAIL end_async_reset: got halted %b pc %h want 0 00", halted, pc); end
        reset = 1'b1;
`else
        n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL end_halted: got %b want 0", halted); end
        wait_valid(20, n);
        n_chk++; if (n != 2 || ir !== 16'h1234) begin n_fail++; $display("FAIL end_continue: got %h after %0d want 1234 after 2", ir, n); end
        n_chk++; if (pc !== 8'd102) begin n_fail++; $display("FAIL end_pc: got %h want 66", pc); end
`endif
        ir_ready = 1'b0;
    endtask

    task automatic test_reset_midway;
        int n;
        do_reset();
        branch_en = 1'b1;
        branch_target = 8'h20;
        step();
        branch_en = 1'b0;
        step();
        n_chk++; if (pc !== 8'h20) begin n_fail++; $display("FAIL rst_pre_pc: got %h want 20", pc); end
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (pc !== 8'h00) begin n_fail++; $display("FAIL rst_cap_pc: got %h want 00", pc); end
        n_chk++; if (ir_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL rst_cap_flags: got valid %b halted %b want 0 0", ir_valid, halted); end
        reset = 1'b1;
        wait_valid(20, n);
        n_chk++; if (n != 2 || ir !== rom[0]) begin n_fail++; $display("FAIL rst_restart: got %h after %0d want %h after 2", ir, n, rom[0]); end
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (ir_valid !== 1'b0 || ir !== 16'h0000) begin n_fail++; $display("FAIL rst_hold: got valid %b ir %h want 0 0000", ir_valid, ir); end
        reset = 1'b1;
    endtask

    task automatic test_random;
        int since;
        logic [7:0] ea, ep;
        logic [15:0] w;
        logic br, rdy, pre, ev;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'hF) w[15:12] = 4'h5;
            rom[i] = w;
        end
        do_reset();
        since = 0;
        ea = 8'h00;
        for (int k = 0; k < 600; k++) begin
            br = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            branch_en = br;
            branch_target = 8'($urandom);
            ir_ready = rdy;
            pre = (since >= 2);
            step();
            if (br) begin
                ea = branch_target;
                since = 0;
            end else if (pre && rdy) begin
                ea = ea + 8'd1;
                since = 0;
            end else begin
                since++;
            end
            ev = (since >= 2);
            ep = ev ? ea + 8'd1 : ea;
            n_chk++; if (ir_valid !== ev) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", k, ir_valid, ev); end
            n_chk++; if (pc !== ep) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", k, pc, ep); end
            if (ev) begin
                n_chk++; if (ir !== rom[ea]) begin n_fail++; $display("FAIL rnd_ir[%0d]: got %h want %h", k, ir, rom[ea]); end
            end
        end
        branch_en = 1'b0;
        ir_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'(i)};
        test_reset();
        test_basic();
        test_stall();
        test_branch();
        test_wrap();
        test_end();
        test_reset_midway();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
